// File: rtl/des_key_schedule.sv
// DES/3DES round-key generator: PC-1 per stage key, C/D rotation per round, PC-2 per subkey.
// Subkeys stream out over valid/ready in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule #(
  parameter int NUM_KEYS     = 1,
  parameter int PARITY_CHECK = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Start,
  input  logic                   Decrypt,
  input  logic [64*NUM_KEYS-1:0] KeyIn,
  output logic                   Busy,
  output logic [47:0]            SubKey,
  output logic                   SubKeyValid,
  input  logic                   SubKeyReady,
  output logic [3:0]             RoundIdx,
  output logic [1:0]             StageIdx,
  output logic                   Done,
  output logic                   ParityErr
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Bit r-1 set when FIPS round r rotates by one position (rounds 1, 2, 9, 16).
  localparam logic [15:0] ONE_SHIFT = 16'b1000_0001_0000_0011;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [64*NUM_KEYS-1:0]  key_reg;
  logic                    dec_reg, parity_reg, stage_dec_reg;
  logic [1:0]              stage_cnt_reg, key_idx_reg;
  logic [3:0]              round_reg;
  logic [27:0]             c_reg, d_reg;

  logic [1:0]  load_idx;
  logic        load_dec, last_round, last_stage, hs, parity_in;
  logic [63:0] stage_key;
  logic [55:0] pc1_cd, cd_cur;
  logic [8*NUM_KEYS-1:0] byte_even;

  // Port bit 0 is FIPS bit 1, so a FIPS left rotation moves bits toward index 0.
  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  genvar gi;
  for (gi = 0; gi < 8*NUM_KEYS; gi++) begin : g_parity
    assign byte_even[gi] = ~^KeyIn[8*gi +: 8];
  end
  assign parity_in = (PARITY_CHECK != 0) && (|byte_even);

  // 3DES EDE: the middle stage always runs opposite to the overall direction.
  assign load_idx = dec_reg ? (2'(NUM_KEYS - 1) - stage_cnt_reg) : stage_cnt_reg;
  assign load_dec = dec_reg ^ (stage_cnt_reg == 2'd1);

  always_comb begin
    stage_key = key_reg[63:0];
    for (int k = 1; k < NUM_KEYS; k++)
      if (load_idx == 2'(k)) stage_key = key_reg[64*k +: 64];
  end

  for (gi = 0; gi < 56; gi++) begin : g_pc1
    assign pc1_cd[gi] = stage_key[PC1[gi]-1];
  end

  assign cd_cur = {d_reg, c_reg};
  for (gi = 0; gi < 48; gi++) begin : g_pc2
    assign SubKey[gi] = cd_cur[PC2[gi]-1];
  end

  assign last_round = stage_dec_reg ? (round_reg == 4'd0) : (round_reg == 4'd15);
  assign last_stage = (stage_cnt_reg == 2'(NUM_KEYS - 1));
  assign hs         = (state_reg == RUN) && SubKeyReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    Busy        = 1'b1;
    SubKeyValid = 1'b0;
    Done        = 1'b0;
    case (state_reg)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_next = LOAD;
      end
      LOAD: state_next = RUN;
      RUN: begin
        SubKeyValid = 1'b1;
        if (hs && last_round) state_next = last_stage ? DONE : LOAD;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg       <= '0;
      dec_reg       <= 1'b0;
      parity_reg    <= 1'b0;
      stage_dec_reg <= 1'b0;
      stage_cnt_reg <= 2'd0;
      key_idx_reg   <= 2'd0;
      round_reg     <= 4'd0;
      c_reg         <= '0;
      d_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: if (Start) begin
          key_reg       <= KeyIn;
          dec_reg       <= Decrypt;
          parity_reg    <= parity_in;
          stage_cnt_reg <= 2'd0;
        end
        LOAD: begin
          key_idx_reg   <= load_idx;
          stage_dec_reg <= load_dec;
          // Decrypt starts at C0/D0, which equals C16/D16 since the rotations total 28.
          if (load_dec) begin
            c_reg     <= pc1_cd[27:0];
            d_reg     <= pc1_cd[55:28];
            round_reg <= 4'd15;
          end else begin
            c_reg     <= rotl(pc1_cd[27:0], 1'b0);
            d_reg     <= rotl(pc1_cd[55:28], 1'b0);
            round_reg <= 4'd0;
          end
        end
        RUN: if (hs) begin
          if (!last_round) begin
            if (stage_dec_reg) begin
              c_reg     <= rotr(c_reg, ~ONE_SHIFT[round_reg]);
              d_reg     <= rotr(d_reg, ~ONE_SHIFT[round_reg]);
              round_reg <= round_reg - 4'd1;
            end else begin
              c_reg     <= rotl(c_reg, ~ONE_SHIFT[round_reg + 4'd1]);
              d_reg     <= rotl(d_reg, ~ONE_SHIFT[round_reg + 4'd1]);
              round_reg <= round_reg + 4'd1;
            end
          end else if (!last_stage) begin
            stage_cnt_reg <= stage_cnt_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RoundIdx  = round_reg;
  assign StageIdx  = key_idx_reg;
  assign ParityErr = parity_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule: single-DES and 3DES instances against a
// FIPS-numbered reference that derives each subkey from the cumulative rotation count.
module tb_des_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, dec, ready, sel3;
  logic [191:0] key_drv;
  logic         start1, start3;
  logic         busy1, v1, done1, pe1, busy3, v3, done3, pe3;
  logic [47:0]  sk1, sk3;
  logic [3:0]   rd1, rd3;
  logic [1:0]   st1, st3;
  logic         m_busy, m_valid, m_done, m_perr;
  logic [47:0]  m_sk;
  logic [3:0]   m_rd;
  logic [1:0]   m_st;

  assign start1  = start & ~sel3;
  assign start3  = start & sel3;
  assign m_busy  = sel3 ? busy3 : busy1;
  assign m_valid = sel3 ? v3 : v1;
  assign m_done  = sel3 ? done3 : done1;
  assign m_perr  = sel3 ? pe3 : pe1;
  assign m_sk    = sel3 ? sk3 : sk1;
  assign m_rd    = sel3 ? rd3 : rd1;
  assign m_st    = sel3 ? st3 : st1;

  des_key_schedule #(.NUM_KEYS(1), .PARITY_CHECK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Start(start1), .Decrypt(dec), .KeyIn(key_drv[63:0]),
    .Busy(busy1), .SubKey(sk1), .SubKeyValid(v1), .SubKeyReady(ready),
    .RoundIdx(rd1), .StageIdx(st1), .Done(done1), .ParityErr(pe1));

  des_key_schedule #(.NUM_KEYS(3), .PARITY_CHECK(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .Start(start3), .Decrypt(dec), .KeyIn(key_drv),
    .Busy(busy3), .SubKey(sk3), .SubKeyValid(v3), .SubKeyReady(ready),
    .RoundIdx(rd3), .StageIdx(st3), .Done(done3), .ParityErr(pe3));

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rd;
    logic [1:0]  st;
  } exp_t;

  int          n_cmp = 0, n_err = 0;
  logic [63:0] fk [3];
  logic [47:0] first_sk, last_sk;
  logic [3:0]  first_rd, last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  // Subkey for FIPS round r (1..16) in FIPS hex form: C_r/D_r are C0/D0 rotated by the
  // total shift up to round r, and bit n of the result is FIPS bit n (MSB = bit 1).
  function automatic logic [47:0] ref_subkey(input logic [63:0] fkey, input int r);
    int          tot, p, q;
    logic [56:1] cd0;
    logic [47:0] res;
    tot = 0;
    for (int k = 0; k < r; k++) tot += SHIFTS[k];
    for (int j = 1; j <= 56; j++) cd0[j] = fkey[64-PC1[j-1]];
    res = '0;
    for (int n = 1; n <= 48; n++) begin
      p = PC2[n-1];
      q = (p <= 28) ? ((p - 1 + tot) % 28) + 1 : ((p - 29 + tot) % 28) + 29;
      res[48-n] = cd0[q];
    end
    return res;
  endfunction

  task automatic run_job(input int nk, input logic d, input int rmode, input bit poke);
    exp_t        q[$];
    exp_t        e;
    int          kidx, r, got, gaps, cyc;
    logic        sdec, perr;
    bit          stall, done_seen, last_hs;
    logic [47:0] hsk;
    logic [3:0]  hrd;
    logic [1:0]  hst;

    for (int s = 0; s < nk; s++) begin
      kidx = d ? nk - 1 - s : s;
      sdec = d ^ (nk == 3 && s == 1);
      for (int i = 0; i < 16; i++) begin
        r    = sdec ? 16 - i : i + 1;
        e.sk = rev48(ref_subkey(fk[kidx], r));
        e.rd = 4'(r - 1);
        e.st = 2'(kidx);
        q.push_back(e);
      end
    end
    perr = 1'b0;
    for (int k = 0; k < nk; k++)
      for (int b = 0; b < 8; b++)
        if (^fk[k][8*b +: 8] == 1'b0) perr = 1'b1;

    sel3    = (nk == 3);
    key_drv = {rev64(fk[2]), rev64(fk[1]), rev64(fk[0])};
    dec     = d;
    ready   = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 64'(m_busy), 64'd1);
    check("load_no_valid", 64'(m_valid), 64'd0);
    check("parity", 64'(m_perr), 64'(perr));
    @(negedge clk);
    check("latency", 64'(m_valid), 64'd1);

    got = 0; gaps = 0; cyc = 0; stall = 0; done_seen = 0; last_hs = 0;
    hsk = '0; hrd = '0; hst = '0;
    while (!done_seen && cyc < 2000) begin
      if (stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_sk", 64'(m_sk), 64'(hsk));
        check("hold_rd", 64'(m_rd), 64'(hrd));
        check("hold_st", 64'(m_st), 64'(hst));
      end
      if (m_done) begin
        done_seen = 1;
        check("done_after_last", 64'(last_hs), 64'd1);
        check("hs_count", 64'(got), 64'(q.size()));
        check("done_no_valid", 64'(m_valid), 64'd0);
      end else if (!m_valid) begin
        gaps++;
      end
      last_hs = 0;
      ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (poke && cyc == 7) begin
        start   = 1'b1;
        key_drv = ~key_drv;
        dec     = ~dec;
      end else begin
        start = 1'b0;
      end
      if (m_valid && ready) begin
        if (got < q.size()) begin
          check("subkey", 64'(m_sk), 64'(q[got].sk));
          check("round", 64'(m_rd), 64'(q[got].rd));
          check("stage", 64'(m_st), 64'(q[got].st));
        end else begin
          check("extra_hs", 64'(got), 64'(q.size()));
        end
        if (got == 0) begin
          first_sk = m_sk;
          first_rd = m_rd;
        end
        last_sk = m_sk;
        last_rd = m_rd;
        got++;
        last_hs = (got == q.size());
      end
      stall = m_valid && !ready;
      hsk = m_sk; hrd = m_rd; hst = m_st;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(done_seen), 64'd1);
    check("busy_off", 64'(m_busy), 64'd0);
    check("done_pulse", 64'(m_done), 64'd0);
    check("parity_hold", 64'(m_perr), 64'(perr));
    check("stage_gaps", 64'(gaps), 64'(nk - 1));
    $display("job nk=%0d dec=%0d rand_ready=%0d poke=%0d: %0d handshakes in %0d cycles",
             nk, d, rmode, poke, got, cyc);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dec = 1'b0; ready = 1'b0; sel3 = 1'b0; key_drv = '0;
    first_sk = '0; last_sk = '0; first_rd = '0; last_rd = '0;
    fk[0] = FIPS_KEY; fk[1] = '0; fk[2] = '0;
    #3;
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_valid", 64'(v1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_sk", 64'(sk1), 64'd0);
    check("rst_rd_st", 64'({rd1, st1}), 64'd0);
    check("rst_perr", 64'(pe1), 64'd0);
    check("rst_dut3", 64'({busy3, v3, done3, pe3, sk3, rd3, st3}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(1, 1'b0, 0, 0);
    check("enc_first", 64'(first_sk), 64'(rev48(FIPS_K1)));
    check("enc_first_rd", 64'(first_rd), 64'd0);
    check("enc_last", 64'(last_sk), 64'(rev48(FIPS_K16)));
    check("enc_last_rd", 64'(last_rd), 64'd15);

    run_job(1, 1'b1, 0, 0);
    check("dec_first", 64'(first_sk), 64'(rev48(FIPS_K16)));
    check("dec_first_rd", 64'(first_rd), 64'd15);
    check("dec_last", 64'(last_sk), 64'(rev48(FIPS_K1)));
    check("dec_last_rd", 64'(last_rd), 64'd0);

    run_job(1, 1'b0, 1, 0);

    for (int k = 0; k < 3; k++) fk[k] = {$urandom, $urandom};
    run_job(3, 1'b0, 1, 0);
    run_job(3, 1'b1, 0, 0);

    fk[0] = '0;
    run_job(1, 1'b0, 0, 1);
    check("zero_perr", 64'(pe1), 64'd1);
    check("zero_first", 64'(first_sk), 64'd0);
    check("zero_last", 64'(last_sk), 64'd0);

    fk[0] = {$urandom, $urandom};
    run_job(1, 1'b1, 1, 1);

    // Abort mid-run with an asynchronous reset between clock edges.
    fk[0] = FIPS_KEY; sel3 = 1'b0; key_drv = {128'd0, rev64(FIPS_KEY)};
    dec = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_valid", 64'(v1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(v1), 64'd0);
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_done", 64'(done1), 64'd0);
    check("abort_sk_rd", 64'({sk1, rd1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(1, 1'b0, 0, 0);
    check("rerun_first", 64'(first_sk), 64'(rev48(FIPS_K1)));
    check("rerun_last", 64'(last_sk), 64'(rev48(FIPS_K16)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
